mem_bus_arbiter: RTL

- Shares the single byte-wide RAM/IO bus between the instruction-fetch port and the load/store (data) port.
- Serializes 1/2/4-byte accesses into byte cycles, little-endian, and assembles read data.
- Holds IO writes while the UART buffer is full.
- Sits between if_/mem stages and the external mem_din/mem_dout/mem_a/mem_wr pins of cpu.

---
 rtl/mem_bus_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares the byte-wide RAM/IO bus between the fetch port and the load/store port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_abort,
    output logic [31:0]       inst_data,
    output logic              inst_done,
    input  logic              data_r_req,
    input  logic              data_w_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_w_data,
    output logic [31:0]       data_r_data,
    output logic              data_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    typedef enum logic [2:0] {IDLE, RD_INST, RD_DATA, WR_DATA, WR_WAIT, DONE} state_t;

    localparam logic [2:0] INST_N = 3'(INST_BYTES);

    state_t            state, next_state;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        cnt, nbytes, data_nbytes, addr_off;
    logic [31:0]       wr_buf, rd_buf;
    logic [7:0]        din_hold, rd_byte;
    logic              owner_data, rdy_q;
    logic              inst_valid, data_valid, grant_data, io_stall;

    assign inst_valid = inst_req && !inst_abort;
    assign data_valid = data_r_req || data_w_req;

`ifdef MEM_ARB_RR_EN
    logic last_grant;
    assign grant_data = data_valid && (!inst_valid || !last_grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= 1'b0;
        else if (rdy && state == IDLE && (data_valid || inst_valid))
            last_grant <= grant_data;
    end
`else
    assign grant_data = data_valid;
`endif

    always_comb begin
        case (data_size)
            2'd0:    data_nbytes = 3'd1;
            2'd1:    data_nbytes = 3'd2;
            default: data_nbytes = 3'd4;
        endcase
    end

    // Reads run one cycle past the last issue, so the address saturates at the final byte.
    assign addr_off = (cnt != 3'd0 && cnt >= nbytes) ? cnt - 3'd1 : cnt;
    assign mem_a    = base_addr + ADDR_W'(addr_off);
    assign io_stall = (mem_a[17:16] == 2'b11) && io_buffer_full;

    // RAM keeps answering during a stall, so the byte due in the first frozen cycle is
    // parked and substituted in the cycle the bus resumes.
    assign rd_byte = (rdy && !rdy_q) ? din_hold : mem_din;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q    <= 1'b1;
            din_hold <= 8'd0;
        end else begin
            rdy_q <= rdy;
            if (rdy_q && !rdy)
                din_hold <= mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (rdy)
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_data)
                    next_state = data_w_req ? WR_DATA : RD_DATA;
                else if (inst_valid)
                    next_state = RD_INST;
            end
            RD_INST: begin
                if (inst_abort)
                    next_state = IDLE;
                else if (cnt == nbytes)
                    next_state = DONE;
            end
            RD_DATA: begin
                if (cnt == nbytes)
                    next_state = DONE;
            end
            WR_DATA, WR_WAIT: begin
                if (io_stall)
                    next_state = WR_WAIT;
                else if (cnt == nbytes - 3'd1)
                    next_state = DONE;
                else
                    next_state = WR_DATA;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_wr      = rdy && (state == WR_DATA || state == WR_WAIT) && !io_stall;
        inst_done   = (state == DONE) && !owner_data && !inst_abort;
        data_done   = (state == DONE) && owner_data;
        inst_data   = inst_done ? rd_buf : 32'd0;
        data_r_data = data_done ? rd_buf : 32'd0;
        case (cnt)
            3'd1:    mem_dout = wr_buf[15:8];
            3'd2:    mem_dout = wr_buf[23:16];
            3'd3:    mem_dout = wr_buf[31:24];
            default: mem_dout = wr_buf[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_addr  <= '0;
            cnt        <= 3'd0;
            nbytes     <= 3'd0;
            wr_buf     <= 32'd0;
            rd_buf     <= 32'd0;
            owner_data <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (grant_data) begin
                        base_addr  <= data_addr;
                        nbytes     <= data_nbytes;
                        wr_buf     <= data_w_data;
                        rd_buf     <= 32'd0;
                        owner_data <= 1'b1;
                    end else if (inst_valid) begin
                        base_addr  <= inst_addr;
                        nbytes     <= INST_N;
                        rd_buf     <= 32'd0;
                        owner_data <= 1'b0;
                    end
                end
                RD_INST, RD_DATA: begin
                    cnt <= cnt + 3'd1;
                    case (cnt)
                        3'd1:    rd_buf[7:0]   <= rd_byte;
                        3'd2:    rd_buf[15:8]  <= rd_byte;
                        3'd3:    rd_buf[23:16] <= rd_byte;
                        3'd4:    rd_buf[31:24] <= rd_byte;
                        default: ;
                    endcase
                end
                WR_DATA, WR_WAIT: begin
                    if (!io_stall)
                        cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
